// File: rtl/eeprom_wr_master.sv
// eeprom_wr_master: I2C master that writes one register of an EEPROM slave.
// It sends START, the device ID (write), the register address, the data byte and STOP,
// and checks the slave ACK after every byte.
// SCL is push-pull. SDA is open-drain through sda_oe (1 = pull low).
//
// Handshake: req is sampled only while the FSM is in IDLE. The cycle after an accepted req,
// busy rises. reg_addr/wdata are captured on the accept edge and are ignored afterwards.
// busy stays high until the single-cycle done pulse, and busy is low during that pulse.
// nack/nack_stage are valid only while done=1. A req seen outside IDLE (including the DONE
// cycle) is dropped, not queued.
module eeprom_wr_master #(
  parameter logic [7:0]  EE_ID = 8'b1010_0000,
  parameter int unsigned QTR   = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic [7:0] reg_addr,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic       nack,
  output logic [1:0] nack_stage,
  output logic       scl_o,
  output logic       sda_oe,
  input  logic       sda_i,
  output logic [3:0] dbg_state
);

  localparam int unsigned   QW       = (QTR > 1) ? $clog2(QTR) : 1;
  localparam logic [QW-1:0] QTR_LAST = QW'(QTR - 1);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_START    = 4'd1,
    S_ID       = 4'd2,
    S_ID_ACK   = 4'd3,
    S_REG      = 4'd4,
    S_REG_ACK  = 4'd5,
    S_DATA     = 4'd6,
    S_DATA_ACK = 4'd7,
    S_STOP     = 4'd8,
    S_DONE     = 4'd9
  } state_t;

  state_t        state_q, state_d;
  logic [QW-1:0] qtr_q, qtr_d;
  logic [1:0]    ph_q, ph_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    addr_q, addr_d;
  logic [7:0]    data_q, data_d;
  logic          ack_q, ack_d;
  logic          nack_rec_q, nack_rec_d;
  logic [1:0]    stage_rec_q, stage_rec_d;

  logic          scl_q, scl_d;
  logic          sda_oe_q, sda_oe_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          nack_q, nack_d;
  logic [1:0]    nack_stage_q, nack_stage_d;
  logic [7:0]    tx_byte;

  logic          qtr_last;
  logic          bit_end;

  assign qtr_last = (qtr_q == QTR_LAST);
  assign bit_end  = qtr_last && (ph_q == 2'd3);

  // Next-state, bit timing and latched-byte logic.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    data_d      = data_q;
    ack_d       = ack_q;
    nack_rec_d  = nack_rec_q;
    stage_rec_d = stage_rec_q;
    bit_d       = bit_q;
    // Quarter/phase counters free-run in every active state and wrap at bit end.
    if (qtr_last) begin
      qtr_d = '0;
      ph_d  = ph_q + 2'd1;
    end else begin
      qtr_d = qtr_q + QW'(1);
      ph_d  = ph_q;
    end

    case (state_q)
      S_IDLE: begin
        qtr_d = '0;
        ph_d  = '0;
        bit_d = '0;
        if (req) begin
          state_d     = S_START;
          addr_d      = reg_addr;
          data_d      = wdata;
          ack_d       = 1'b0;
          nack_rec_d  = 1'b0;
          stage_rec_d = 2'd0;
        end
      end
      S_START: begin
        if (bit_end) state_d = S_ID;
      end
      S_ID, S_REG, S_DATA: begin
        if (bit_end) begin
          if (bit_q == 3'd7) begin
            bit_d = '0;
            case (state_q)
              S_ID:    state_d = S_ID_ACK;
              S_REG:   state_d = S_REG_ACK;
              default: state_d = S_DATA_ACK;
            endcase
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      S_ID_ACK, S_REG_ACK, S_DATA_ACK: begin
        // Sample the slave on the last SCL-high cycle of ph2, decide at bit end.
        if (qtr_last && (ph_q == 2'd2)) ack_d = sda_i;
        if (bit_end) begin
          if (ack_q) begin
            state_d    = S_STOP;
            nack_rec_d = 1'b1;
            case (state_q)
              S_ID_ACK:  stage_rec_d = 2'd1;
              S_REG_ACK: stage_rec_d = 2'd2;
              default:   stage_rec_d = 2'd3;
            endcase
          end else begin
            case (state_q)
              S_ID_ACK:  state_d = S_REG;
              S_REG_ACK: state_d = S_DATA;
              default:   state_d = S_STOP;
            endcase
          end
        end
      end
      S_STOP: begin
        if (bit_end) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
        qtr_d   = '0;
        ph_d    = '0;
      end
      default: begin
        state_d     = S_IDLE;
        qtr_d       = '0;
        ph_d        = '0;
        bit_d       = '0;
        addr_d      = '0;
        data_d      = '0;
        ack_d       = 1'b0;
        nack_rec_d  = 1'b0;
        stage_rec_d = 2'd0;
      end
    endcase
  end

  // Pin and status values for the upcoming cycle, decoded from the next state so they register in step with it.
  always_comb begin
    scl_d        = 1'b1;
    sda_oe_d     = 1'b0;
    busy_d       = 1'b0;
    done_d       = 1'b0;
    nack_d       = 1'b0;
    nack_stage_d = 2'd0;
    tx_byte      = 8'h00;
    case (state_d)
      S_ID:   tx_byte = EE_ID;
      S_REG:  tx_byte = addr_d;
      S_DATA: tx_byte = data_d;
      default: tx_byte = 8'h00;
    endcase

    case (state_d)
      S_START: begin
        // SDA falls in ph2 with SCL high (START), SCL falls in ph3.
        busy_d   = 1'b1;
        scl_d    = (ph_d != 2'd3);
        sda_oe_d = ph_d[1];
      end
      S_ID, S_REG, S_DATA: begin
        // Bit value is constant for the whole bit, so SDA only moves at the start of ph0.
        busy_d   = 1'b1;
        scl_d    = ph_d[1];
        sda_oe_d = ~tx_byte[3'd7 - bit_d];
      end
      S_ID_ACK, S_REG_ACK, S_DATA_ACK: begin
        busy_d   = 1'b1;
        scl_d    = ph_d[1];
        sda_oe_d = 1'b0;
      end
      S_STOP: begin
        // SDA held low through the SCL rise, released in ph2 with SCL high (STOP).
        busy_d   = 1'b1;
        scl_d    = (ph_d != 2'd0);
        sda_oe_d = ~ph_d[1];
      end
      S_DONE: begin
        done_d       = 1'b1;
        nack_d       = nack_rec_d;
        nack_stage_d = stage_rec_d;
      end
      default: begin
        scl_d    = 1'b1;
        sda_oe_d = 1'b0;
      end
    endcase
  end

  // Single state register for FSM, counters, latched bytes and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      qtr_q        <= '0;
      ph_q         <= '0;
      bit_q        <= '0;
      addr_q       <= '0;
      data_q       <= '0;
      ack_q        <= 1'b0;
      nack_rec_q   <= 1'b0;
      stage_rec_q  <= 2'd0;
      scl_q        <= 1'b1;
      sda_oe_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      nack_q       <= 1'b0;
      nack_stage_q <= 2'd0;
    end else begin
      state_q      <= state_d;
      qtr_q        <= qtr_d;
      ph_q         <= ph_d;
      bit_q        <= bit_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      ack_q        <= ack_d;
      nack_rec_q   <= nack_rec_d;
      stage_rec_q  <= stage_rec_d;
      scl_q        <= scl_d;
      sda_oe_q     <= sda_oe_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      nack_q       <= nack_d;
      nack_stage_q <= nack_stage_d;
    end
  end

  assign scl_o      = scl_q;
  assign sda_oe     = sda_oe_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign nack       = nack_q;
  assign nack_stage = nack_stage_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_eeprom_wr_master.sv
// Bench for eeprom_wr_master: two instances (QTR=5 and QTR=2) share one bus monitor /
// slave model that follows the selected instance. The slave decodes bytes from the
// pins, ACKs or NACKs per transaction, and counts START/STOP/illegal SDA edges.
`timescale 1ns/1ps
module tb_eeprom_wr_master;

  localparam int         QTR_A = 5;
  localparam int         QTR_B = 2;
  localparam logic [7:0] EE_ID = 8'hA0;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]      req;
  logic [1:0][7:0] reg_addr;
  logic [1:0][7:0] wdata;
  wire  [1:0]      busy, done, nack, scl_o, sda_oe, sda_i;
  wire  [1:0][1:0] nack_stage;
  wire  [1:0][3:0] dbg_state;

  eeprom_wr_master #(.EE_ID(EE_ID), .QTR(QTR_A)) u_dut_a (
    .clk(clk), .rst(rst), .req(req[0]), .reg_addr(reg_addr[0]), .wdata(wdata[0]),
    .busy(busy[0]), .done(done[0]), .nack(nack[0]), .nack_stage(nack_stage[0]),
    .scl_o(scl_o[0]), .sda_oe(sda_oe[0]), .sda_i(sda_i[0]), .dbg_state(dbg_state[0])
  );

  eeprom_wr_master #(.EE_ID(EE_ID), .QTR(QTR_B)) u_dut_b (
    .clk(clk), .rst(rst), .req(req[1]), .reg_addr(reg_addr[1]), .wdata(wdata[1]),
    .busy(busy[1]), .done(done[1]), .nack(nack[1]), .nack_stage(nack_stage[1]),
    .scl_o(scl_o[1]), .sda_oe(sda_oe[1]), .sda_i(sda_i[1]), .dbg_state(dbg_state[1])
  );

  // ---------------- slave model / bus monitor ----------------
  logic       sel;
  int         nack_at;      // 0 = ACK all, 1/2/3 = NACK ID/REG/DATA
  logic       pull;
  int         bitc;
  int         byte_idx;
  logic [7:0] sh;
  int         starts, stops, bad_edges;
  logic       prev_scl, prev_oe;
  logic       m_scl, m_oe, pin;
  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];

  assign sda_i[0] = ~sda_oe[0] & ~(pull & (sel == 1'b0));
  assign sda_i[1] = ~sda_oe[1] & ~(pull & (sel == 1'b1));

  always @(negedge clk) begin
    m_scl = scl_o[sel];
    m_oe  = sda_oe[sel];
    pin   = ~m_oe & ~pull;
    if (rst) begin
      pull     = 1'b0;
      bitc     = 0;
      byte_idx = 0;
    end else begin
      if (prev_scl && m_scl && (m_oe != prev_oe)) begin
        if (m_oe) begin
          starts++;
          bitc     = 0;
          byte_idx = 0;
          pull     = 1'b0;
        end else begin
          stops++;
        end
      end
      if (!prev_scl && m_scl) begin
        if (m_oe != prev_oe) bad_edges++;
        if (bitc < 8) begin
          sh = {sh[6:0], pin};
          if (bitc == 7) rx_q.push_back(sh);
        end
        bitc++;
      end
      if (prev_scl && !m_scl) begin
        if (bitc == 8) begin
          pull = ((byte_idx + 1) != nack_at);
        end else if (bitc == 9) begin
          pull     = 1'b0;
          bitc     = 0;
          byte_idx++;
        end
      end
    end
    prev_scl = m_scl;
    prev_oe  = m_oe;
  end

  // ---------------- checking ----------------
  int n_cmp;
  int n_bad;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic int bit_cyc(input logic g);
    return 4 * ((g == 1'b0) ? QTR_A : QTR_B);
  endfunction

  // ---------------- driver: one write transaction ----------------
  task automatic run_txn(input logic g, input logic [7:0] a, input logic [7:0] d,
                         input int nk, input bit hold);
    int n;
    int nbytes;
    bit got;
    sel       = g;
    nack_at   = nk;
    rx_q.delete();
    starts    = 0;
    stops     = 0;
    bad_edges = 0;

    // Reference: bytes sent stop at the first NACKed byte; every byte costs 9 bits,
    // plus one START and one STOP bit.
    nbytes = (nk == 0) ? 3 : nk;
    exp_q.delete();
    exp_q.push_back(EE_ID);
    if (nbytes > 1) exp_q.push_back(a);
    if (nbytes > 2) exp_q.push_back(d);

    @(negedge clk);
    req[g]      = 1'b1;
    reg_addr[g] = a;
    wdata[g]    = d;
    n   = 0;
    got = 1'b0;
    while (n < 4000 && !got) begin
      @(negedge clk);
      n++;
      if (n == 1) chk("busy_after_accept", int'(busy[g]), 1);
      if (hold) begin
        reg_addr[g] = 8'($urandom);
        wdata[g]    = 8'($urandom);
      end else if (n == 1) begin
        req[g] = 1'b0;
      end
      if (done[g]) got = 1'b1;
    end
    chk("done_seen", int'(got), 1);
    chk("latency", n - 1, bit_cyc(g) * (2 + 9 * nbytes));
    chk("busy_in_done", int'(busy[g]), 0);
    chk("nack", int'(nack[g]), (nk != 0) ? 1 : 0);
    chk("nack_stage", int'(nack_stage[g]), nk);

    // req (if held) was still high across the DONE cycle; it must not start a transfer.
    @(negedge clk);
    req[g] = 1'b0;
    chk("done_one_cycle", int'(done[g]), 0);
    chk("busy_after_done", int'(busy[g]), 0);
    repeat (3) @(negedge clk);
    chk("idle_busy", int'(busy[g]), 0);
    chk("idle_scl", int'(scl_o[g]), 1);
    chk("idle_sda_oe", int'(sda_oe[g]), 0);

    chk("start_edges", starts, 1);
    chk("stop_edges", stops, 1);
    chk("sda_change_on_scl_rise", bad_edges, 0);
    chk("byte_count", rx_q.size(), exp_q.size());
    while (exp_q.size() > 0 && rx_q.size() > 0)
      chk("pin_byte", int'(rx_q.pop_front()), int'(exp_q.pop_front()));
  endtask

  // ---------------- driver: reset in the middle of the DATA byte ----------------
  task automatic reset_abort();
    sel       = 1'b0;
    nack_at   = 0;
    @(negedge clk);
    req[0]      = 1'b1;
    reg_addr[0] = 8'hC3;
    wdata[0]    = 8'h96;
    @(negedge clk);
    req[0] = 1'b0;
    // DATA occupies cycles 380..539 after accept at QTR=5.
    repeat (459) @(negedge clk);
    chk("busy_before_abort", int'(busy[0]), 1);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_scl", int'(scl_o[0]), 1);
      chk("abort_sda_oe", int'(sda_oe[0]), 0);
      chk("abort_busy", int'(busy[0]), 0);
      chk("abort_done", int'(done[0]), 0);
    end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_abort_done", int'(done[0]), 0);
      chk("post_abort_busy", int'(busy[0]), 0);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [7:0] ra, rd;
    n_cmp     = 0;
    n_bad     = 0;
    sel       = 1'b0;
    nack_at   = 0;
    pull      = 1'b0;
    bitc      = 0;
    byte_idx  = 0;
    sh        = 8'h00;
    starts    = 0;
    stops     = 0;
    bad_edges = 0;
    prev_scl  = 1'b1;
    prev_oe   = 1'b0;
    rst       = 1'b1;
    req       = '0;
    reg_addr  = '0;
    wdata     = '0;

    repeat (4) @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      chk("rst_scl", int'(scl_o[g]), 1);
      chk("rst_sda_oe", int'(sda_oe[g]), 0);
      chk("rst_busy", int'(busy[g]), 0);
      chk("rst_done", int'(done[g]), 0);
      chk("rst_nack", int'(nack[g]), 0);
      chk("rst_nack_stage", int'(nack_stage[g]), 0);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);

    reset_abort();
    run_txn(1'b0, 8'h3C, 8'h5A, 0, 1'b0);
    run_txn(1'b0, 8'h3C, 8'h5A, 1, 1'b0);
    ra = 8'($urandom); rd = 8'($urandom);
    run_txn(1'b0, ra, rd, 3, 1'b0);
    ra = 8'($urandom); rd = 8'($urandom);
    run_txn(1'b0, ra, rd, 0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      ra = 8'($urandom); rd = 8'($urandom);
      run_txn(1'b0, ra, rd, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    run_txn(1'b1, 8'hFF, 8'h00, 0, 1'b0);
    run_txn(1'b1, 8'h01, 8'h80, 2, 1'b0);
    for (int i = 0; i < 4; i++) begin
      ra = 8'($urandom); rd = 8'($urandom);
      run_txn(1'b1, ra, rd, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
